er_metric_monitor: RTL and testbench
====================================

# er_metric_monitor

Synthesizable error-metric collector for the approximate-adder evaluation flow. It accepts a stream of (approximate sum, exact sum) pairs over a valid/ready handshake and accumulates the following statistics:
- error count (samples where the two sums differ)
- total error distance
- maximum error distance

At the end of a run it computes the integer mean error distance with a sequential divider. It sits downstream of an adder-under-test and its exact-adder reference, so error rate, MED and max-ED measurements can run on-chip at full clock rate.

## Interface
Parameters:
- N, 16, sum width of the adder under test
- CW, 32, sample-counter width
- AW, 48, accumulator and quotient width; must satisfy AW >= N+CW

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse: clear statistics, latch num_samples, begin run
- num_samples  in  CW  samples per run; sampled only on accepted start
- in_valid  in  1  sample pair valid
- in_ready  out  1  monitor accepting samples
- approx_sum  in  N  sum from adder under test
- exact_sum  in  N  exact reference sum
- busy  out  1  run in progress (COLLECT or DIVIDE)
- done  out  1  results final; level, held until next accepted start
- err_count  out  CW  samples with approx_sum != exact_sum
- total_ed  out  AW  sum of |approx_sum - exact_sum|
- max_ed  out  N  largest single error distance
- med  out  AW  floor(total_ed / num_samples); valid when done=1

## Operation
- States: IDLE, COLLECT, DIVIDE, DONE.
- Reset (async, any state) -> IDLE. All outputs and internal registers are 0, including in_ready, busy, done and every statistic.
- start is accepted in IDLE or DONE only. On acceptance:
  - clear err_count, total_ed, max_ed, med and the sample counter; done <= 0
  - latch num_samples
  - if num_samples == 0: go to DONE (all statistics 0, med 0)
  - otherwise go to COLLECT
- start in COLLECT or DIVIDE is ignored.
- COLLECT: in_ready=1, busy=1. A sample is accepted when in_valid && in_ready. On each accepted sample:
  - ed = |approx_sum - exact_sum|, computed as an unsigned N-bit magnitude (larger minus smaller, so no wrap)
  - err_count += (ed != 0)
  - total_ed += zero-extended ed
  - max_ed = max(max_ed, ed)
  - sample counter += 1
- The accumulators cannot overflow because AW >= N+CW.
- When the accepted sample is number num_samples: go to DIVIDE. in_ready drops the following cycle and no further samples are taken.
- DIVIDE: busy=1, in_ready=0. Restoring shift-subtract divider, one quotient bit per cycle, MSB first, exactly AW cycles. Dividend is total_ed; divisor is the latched num_samples, zero-extended. At the end, med <= quotient and the state goes to DONE.
- DONE: done=1, busy=0, in_ready=0. All statistics are held.
- in_valid while not in COLLECT is ignored. Sample data is never stored outside COLLECT.

## Timing
- start accepted at edge t:
  - busy=1 and in_ready=1 from t+1 (nonzero num_samples)
  - done=1 from t+1 (num_samples == 0)
- Statistic registers update on the edge that accepts a sample and are visible the next cycle. err_count, total_ed and max_ed are live during COLLECT. med is valid only when done=1.
- Last sample accepted at edge t: DIVIDE occupies cycles t+1 .. t+AW; med and done are visible from t+AW+1.
- Throughput: one sample per cycle with no bubbles while in COLLECT.
- start and in_valid are both sampled; in_valid in the cycle start is accepted is ignored because the state is not yet COLLECT.
- rst asserted mid-run aborts immediately. Outputs read 0 while rst is high; no partial result is retained.

## Test plan
- num_samples=4; pairs (10,10), (12,10), (5,9), (0,0xFFFF) back-to-back -> err_count=3, total_ed=65541, max_ed=65535, med=16385. done rises exactly AW+1 cycles after the 4th accept.
- num_samples=3; in_valid pattern 1,0,0,1,0,1 with pairs differing by 7 each -> only 3 accepts counted, err_count=3, total_ed=21, med=7. in_ready=0 after the 3rd accept.
- start with num_samples=0 -> done=1 on the next cycle; all statistics 0; busy never asserts.
- During COLLECT: assert start, and separately drive in_valid in IDLE/DONE -> no effect on counters or state. Then assert rst mid-DIVIDE -> all outputs 0 immediately; a new start then runs cleanly from zero.
- 1000 identical pairs (approx == exact) -> err_count=0, total_ed=0, max_ed=0, med=0, done asserted.
- 10000 random N-bit pairs, with approx_sum taken from an approximate adder model -> err_count, total_ed, max_ed and med match a bench scoreboard exactly (med = floor of the integer division).

Source files
------------

// File: rtl/er_metric_monitor.sv
// er_metric_monitor
// Collects error statistics for an approximate adder against its exact
// reference. It counts mismatches, accumulates total and maximum error
// distance, and finishes with a restoring divider that produces the integer
// mean error distance.
module er_metric_monitor #(
   parameter int N  = 16,
   parameter int CW = 32,
   parameter int AW = 48
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] num_samples,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  approx_sum,
   input  logic [N-1:0]  exact_sum,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] err_count,
   output logic [AW-1:0] total_ed,
   output logic [N-1:0]  max_ed,
   output logic [AW-1:0] med
);

   localparam int DCW = $clog2(AW);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DIVIDE  = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t state_reg, state_next;

   // Run bookkeeping and statistics
   logic [CW-1:0]  n_reg, n_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic [CW-1:0]  err_count_reg, err_count_next;
   logic [AW-1:0]  total_ed_reg, total_ed_next;
   logic [N-1:0]   max_ed_reg, max_ed_next;
   logic [AW-1:0]  med_reg, med_next;

   // Divider state: quotient register doubles as the dividend shift register.
   // The partial remainder is always smaller than the divisor, so CW bits hold it.
   logic [AW-1:0]  quot_reg, quot_next;
   logic [CW-1:0]  rem_reg, rem_next;
   logic [DCW-1:0] div_cnt_reg, div_cnt_next;

   // Datapath helpers
   logic [N-1:0]   ed;
   logic [AW-1:0]  total_ed_sum;
   logic [CW:0]    rem_shift;
   logic [CW:0]    rem_diff;
   logic           rem_ge;
   logic [AW-1:0]  quot_shift;

   // Error distance as an unsigned magnitude: larger minus smaller never wraps
   assign ed = (approx_sum >= exact_sum) ? (approx_sum - exact_sum)
                                         : (exact_sum - approx_sum);

   assign total_ed_sum = total_ed_reg + {{(AW-N){1'b0}}, ed};

   // One restoring-division step: bring in the next dividend bit, trial subtract
   assign rem_shift  = {rem_reg, quot_reg[AW-1]};
   assign rem_diff   = rem_shift - {1'b0, n_reg};
   assign rem_ge     = (rem_shift >= {1'b0, n_reg});
   assign quot_shift = {quot_reg[AW-2:0], rem_ge};

   // Status outputs decode directly from the registered state
   assign in_ready  = (state_reg == COLLECT);
   assign busy      = (state_reg == COLLECT) || (state_reg == DIVIDE);
   assign done      = (state_reg == DONE);
   assign err_count = err_count_reg;
   assign total_ed  = total_ed_reg;
   assign max_ed    = max_ed_reg;
   assign med       = med_reg;

   // Next-state and datapath update for the run controller
   always_comb begin
      state_next     = state_reg;
      n_next         = n_reg;
      cnt_next       = cnt_reg;
      err_count_next = err_count_reg;
      total_ed_next  = total_ed_reg;
      max_ed_next    = max_ed_reg;
      med_next       = med_reg;
      quot_next      = quot_reg;
      rem_next       = rem_reg;
      div_cnt_next   = div_cnt_reg;

      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               n_next         = num_samples;
               cnt_next       = '0;
               err_count_next = '0;
               total_ed_next  = '0;
               max_ed_next    = '0;
               med_next       = '0;
               quot_next      = '0;
               rem_next       = '0;
               div_cnt_next   = '0;
               state_next     = (num_samples == '0) ? DONE : COLLECT;
            end
         end

         COLLECT: begin
            if (in_valid) begin
               cnt_next      = cnt_reg + CW'(1);
               total_ed_next = total_ed_sum;
               if (ed != '0) begin
                  err_count_next = err_count_reg + CW'(1);
               end
               if (ed > max_ed_reg) begin
                  max_ed_next = ed;
               end
               // Last sample of the run: load the divider with the final total
               if (cnt_reg == n_reg - CW'(1)) begin
                  quot_next    = total_ed_sum;
                  rem_next     = '0;
                  div_cnt_next = '0;
                  state_next   = DIVIDE;
               end
            end
         end

         DIVIDE: begin
            quot_next    = quot_shift;
            rem_next     = rem_ge ? rem_diff[CW-1:0] : rem_shift[CW-1:0];
            div_cnt_next = div_cnt_reg + DCW'(1);
            if (div_cnt_reg == DCW'(AW-1)) begin
               med_next   = quot_shift;
               state_next = DONE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register; reset aborts any run immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Statistics and divider registers; reset leaves no partial result behind
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_reg         <= '0;
         cnt_reg       <= '0;
         err_count_reg <= '0;
         total_ed_reg  <= '0;
         max_ed_reg    <= '0;
         med_reg       <= '0;
         quot_reg      <= '0;
         rem_reg       <= '0;
         div_cnt_reg   <= '0;
      end else begin
         n_reg         <= n_next;
         cnt_reg       <= cnt_next;
         err_count_reg <= err_count_next;
         total_ed_reg  <= total_ed_next;
         max_ed_reg    <= max_ed_next;
         med_reg       <= med_next;
         quot_reg      <= quot_next;
         rem_reg       <= rem_next;
         div_cnt_reg   <= div_cnt_next;
      end
   end

endmodule

// File: tb/tb_er_metric_monitor.sv
// Testbench for er_metric_monitor: directed runs plus a random run against
// an approximate-adder model, with a done-triggered scoreboard monitor.
`timescale 1ns/1ps
module tb_er_metric_monitor;

   localparam int N  = 16;
   localparam int CW = 32;
   localparam int AW = 48;
   localparam int NRAND = 10000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] num_samples = '0;
   logic          in_valid = 1'b0;
   logic [N-1:0]  approx_sum = '0;
   logic [N-1:0]  exact_sum = '0;
   logic          in_ready;
   logic          busy;
   logic          done;
   logic [CW-1:0] err_count;
   logic [AW-1:0] total_ed;
   logic [N-1:0]  max_ed;
   logic [AW-1:0] med;

   er_metric_monitor #(.N(N), .CW(CW), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_samples (num_samples),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .approx_sum  (approx_sum),
      .exact_sum   (exact_sum),
      .busy        (busy),
      .done        (done),
      .err_count   (err_count),
      .total_ed    (total_ed),
      .max_ed      (max_ed),
      .med         (med)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint unsigned err;
      longint unsigned tot;
      longint unsigned mx;
      longint unsigned md;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;
   int   run_id = 0;
   logic done_prev = 1'b0;

   task automatic check(input string name, input longint unsigned act, input longint unsigned req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push_exp(input longint unsigned e, input longint unsigned t,
                           input longint unsigned m, input longint unsigned d);
      exp_t x;
      x.err = e; x.tot = t; x.mx = m; x.md = d;
      exp_q.push_back(x);
   endtask

   // Scoreboard monitor: every rising edge of done is a finished run
   always @(negedge clk) begin
      if (done && !done_prev) begin
         run_id++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: run %0d completed with no expected result queued", run_id);
         end else begin
            mon_e = exp_q.pop_front();
            check("run_err_count", longint'(err_count), mon_e.err);
            check("run_total_ed", longint'(total_ed), mon_e.tot);
            check("run_max_ed", longint'(max_ed), mon_e.mx);
            check("run_med", longint'(med), mon_e.md);
            $display("run %0d: err_count=%0d total_ed=%0d max_ed=%0d med=%0d",
                     run_id, err_count, total_ed, max_ed, med);
         end
      end
      done_prev = done;
   end

   // Pulse start for one cycle; returns at the negedge after acceptance
   task automatic do_start(input logic [CW-1:0] n);
      @(negedge clk);
      start = 1'b1;
      num_samples = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Present one sample; called and returning at a negedge, no bubble between calls
   task automatic send(input logic [N-1:0] a, input logic [N-1:0] e);
      int guard = 0;
      in_valid = 1'b1;
      approx_sum = a;
      exact_sum = e;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         check("send_ready_timeout", 0, 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait for done with a bound, then one more cycle so the monitor has run
   task automatic wait_done(input int limit);
      int k = 0;
      while (!done && k < limit) begin
         @(negedge clk);
         k++;
      end
      if (!done) begin
         check("done_timeout", 0, 1);
      end
      @(negedge clk);
   endtask

   int unsigned ra[NRAND];
   int unsigned re[NRAND];

   initial begin
      int k;
      longint unsigned m_err, m_tot, m_max;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", longint'(in_ready), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_stats", longint'(err_count) + longint'(total_ed) + longint'(max_ed) + longint'(med), 0);
      rst = 1'b0;

      // in_valid in IDLE is ignored
      in_valid = 1'b1; approx_sum = 16'd5; exact_sum = 16'd1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check("idle_busy", longint'(busy), 0);
      check("idle_err_count", longint'(err_count), 0);
      check("idle_total_ed", longint'(total_ed), 0);

      // Zero-sample run: done next cycle, busy never asserts
      push_exp(0, 0, 0, 0);
      do_start('0);
      check("zero_done", longint'(done), 1);
      check("zero_busy", longint'(busy), 0);
      @(negedge clk);

      // Run A: four back-to-back samples, latency of done
      push_exp(3, 65541, 65535, 16385);
      do_start(32'd4);
      check("a_busy", longint'(busy), 1);
      check("a_in_ready", longint'(in_ready), 1);
      check("a_done_cleared", longint'(done), 0);
      send(16'd10, 16'd10);
      send(16'd12, 16'd10);
      check("a_live_err_count", longint'(err_count), 1);
      check("a_live_total_ed", longint'(total_ed), 2);
      send(16'd5, 16'd9);
      send(16'd0, 16'hFFFF);
      check("a_ready_drop", longint'(in_ready), 0);
      k = 0;
      while (!done && k < AW + 20) begin
         @(negedge clk);
         k++;
      end
      check("a_done_latency", longint'(k), longint'(AW));
      @(negedge clk);

      // Run B: gapped in_valid pattern 1,0,0,1,0,1
      push_exp(3, 21, 7, 7);
      do_start(32'd3);
      send(16'd107, 16'd100);
      repeat (2) @(negedge clk);
      check("b_gap_err_count", longint'(err_count), 1);
      send(16'd3, 16'd10);
      @(negedge clk);
      send(16'd50, 16'd43);
      check("b_ready_after_last", longint'(in_ready), 0);
      wait_done(AW + 10);

      // Run C: start during COLLECT is ignored
      push_exp(2, 11, 7, 5);
      do_start(32'd2);
      send(16'd5, 16'd1);
      start = 1'b1; num_samples = 32'd9;
      @(negedge clk);
      start = 1'b0;
      check("c_start_ignored_busy", longint'(busy), 1);
      check("c_start_ignored_err", longint'(err_count), 1);
      send(16'd1, 16'd8);
      wait_done(AW + 10);

      // in_valid in DONE is ignored
      in_valid = 1'b1; approx_sum = 16'd0; exact_sum = 16'd500;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check("done_hold_err", longint'(err_count), 2);
      check("done_hold_total", longint'(total_ed), 11);
      check("done_hold_done", longint'(done), 1);
      check("done_hold_ready", longint'(in_ready), 0);

      // Reset mid-DIVIDE aborts with everything cleared
      do_start(32'd1);
      send(16'd0, 16'd100);
      repeat (5) @(negedge clk);
      check("d_in_divide_busy", longint'(busy), 1);
      rst = 1'b1;
      #1;
      check("d_rst_busy", longint'(busy), 0);
      check("d_rst_done", longint'(done), 0);
      check("d_rst_total_ed", longint'(total_ed), 0);
      check("d_rst_err_max", longint'(err_count) + longint'(max_ed), 0);
      @(negedge clk);
      rst = 1'b0;

      // Clean run after abort
      push_exp(1, 2, 2, 2);
      do_start(32'd1);
      check("e_fresh_total_ed", longint'(total_ed), 0);
      send(16'd3, 16'd1);
      wait_done(AW + 10);

      // 1000 identical pairs
      push_exp(0, 0, 0, 0);
      do_start(32'd1000);
      for (int i = 0; i < 1000; i++) begin
         send(N'(i * 37), N'(i * 37));
      end
      wait_done(AW + 10);

      // Random run: lower-part OR adder (4 low bits ORed) versus exact add
      m_err = 0; m_tot = 0; m_max = 0;
      for (int i = 0; i < NRAND; i++) begin
         int unsigned x, y, lo, cin, hi, ap, ex, d;
         x = $urandom_range(0, 32767);
         y = $urandom_range(0, 32767);
         ex = x + y;
         lo = (x | y) & 32'd15;
         cin = ((x >> 3) & (y >> 3)) & 32'd1;
         hi = (x >> 4) + (y >> 4) + cin;
         ap = (hi << 4) | lo;
         d = (ap > ex) ? ap - ex : ex - ap;
         ra[i] = ap;
         re[i] = ex;
         if (d != 0) m_err++;
         m_tot += d;
         if (d > m_max) m_max = d;
      end
      push_exp(m_err, m_tot, m_max, m_tot / NRAND);
      do_start(CW'(NRAND));
      for (int i = 0; i < NRAND; i++) begin
         send(N'(ra[i]), N'(re[i]));
      end
      wait_done(AW + 10);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", longint'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
